line_buffer_window: RTL and testbench

//   3x3 pixel-window generator between the UART RX FIFO bridge and the sobel stage.
//   - Stores an incoming 8-bit raster stream in 4 rotating line buffers.
//   - Once 3 full lines are buffered, emits one 72-bit 3x3 window per cycle for a whole line.
//   - Pulses o_intr so the upstream bridge sends the next line.

---
 rtl/lb_pkg.sv | 25 ++
 rtl/lb_line_ram.sv | 41 ++++
 rtl/line_buffer_window.sv | 181 ++++++++++++++++++
 tb/tb_line_buffer_window.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/lb_pkg.sv
// Shared constants, width helpers and read-FSM state for the 3x3 line-buffer window.
package lb_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned LINE_W    = 512;
    localparam int unsigned NUM_LINES = 4;
    localparam int unsigned WIN       = 3;
    localparam int unsigned IDX_W     = $clog2(NUM_LINES);

    typedef enum logic {
        IDLE = 1'b0,
        RD   = 1'b1
    } rd_state_e;

    // Fill counter must represent 0 .. NUM_LINES*line_w inclusive
    function automatic int unsigned fill_w(input int unsigned line_w);
        return $clog2(NUM_LINES * line_w + 1);
    endfunction

    // Pixel pointer width within one line
    function automatic int unsigned ptr_w(input int unsigned line_w);
        return (line_w > 1) ? $clog2(line_w) : 1;
    endfunction

endpackage

// File: rtl/lb_line_ram.sv
// One image line of storage: synchronous write port, three combinational
// read taps at rd_addr, rd_addr+1 and rd_addr+2 (wrapping modulo the line length).
module lb_line_ram
    import lb_pkg::*;
#(
    parameter int unsigned DW = lb_pkg::DATA_W,
    parameter int unsigned LW = lb_pkg::LINE_W
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [ptr_w(LW)-1:0]     wr_addr,
    input  logic [DW-1:0]            wr_data,
    input  logic [ptr_w(LW)-1:0]     rd_addr,
    output logic [3*DW-1:0]          taps
);

    localparam int unsigned AW = ptr_w(LW);

    logic [DW-1:0] mem [LW];
    logic [AW-1:0] addr1;
    logic [AW-1:0] addr2;

    // Line storage; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Neighbour addresses wrap at the end of the line
    always_comb begin
        addr1 = (rd_addr == AW'(LW - 1)) ? '0 : rd_addr + AW'(1);
        addr2 = (addr1   == AW'(LW - 1)) ? '0 : addr1   + AW'(1);
    end

    // Leftmost tap in the MSBs
    always_comb begin
        taps = {mem[rd_addr], mem[addr1], mem[addr2]};
    end

endmodule

// File: rtl/line_buffer_window.sv
// 3x3 pixel-window generator: buffers a raster stream in four rotating line
// RAMs and, once three lines are held, emits one window per cycle for a line.
// Optional build macro LB_OVERFLOW_DET_EN adds a sticky o_overflow flag and
// drops writes that arrive while all four lines are full and no read is active.
module line_buffer_window
    import lb_pkg::*;
#(
    parameter int unsigned DATA_W = lb_pkg::DATA_W,
    parameter int unsigned LINE_W = lb_pkg::LINE_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_W-1:0]     i_pixel_data,
    input  logic                  i_pixel_data_valid,
    output logic [9*DATA_W-1:0]   o_pixel_data,
    output logic                  o_pixel_data_valid,
    output logic                  o_intr
`ifdef LB_OVERFLOW_DET_EN
    ,
    output logic                  o_overflow
`endif
);

    localparam int unsigned PTR_W  = ptr_w(LINE_W);
    localparam int unsigned FILL_W = fill_w(LINE_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(NUM_LINES * LINE_W);
    localparam logic [FILL_W-1:0] FILL_THR  = FILL_W'(WIN * LINE_W);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(LINE_W - 1);

    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [IDX_W-1:0]     wr_idx;
    logic [IDX_W-1:0]     rd_idx;
    logic [IDX_W-1:0]     r1_idx;
    logic [IDX_W-1:0]     r2_idx;
    logic [FILL_W-1:0]    fill;
    rd_state_e            state;
    rd_state_e            state_nxt;
    logic                 rd_strobe;
    logic                 rd_last;
    logic                 fill_full;
    logic                 wr_en;
    logic [NUM_LINES-1:0] ram_we;
    logic [3*DATA_W-1:0]  taps [NUM_LINES];
    logic [9*DATA_W-1:0]  win_c;

    // Status decode and write acceptance
    always_comb begin
        fill_full = (fill == FILL_FULL);
        rd_last   = (rd_ptr == PTR_LAST);
`ifdef LB_OVERFLOW_DET_EN
        wr_en     = i_pixel_data_valid && !(fill_full && !rd_strobe);
`else
        wr_en     = i_pixel_data_valid;
`endif
    end

    // One-hot write enable for the line currently being filled
    always_comb begin
        ram_we = '0;
        for (int b = 0; b < NUM_LINES; b++) begin
            ram_we[b] = wr_en && (wr_idx == IDX_W'(b));
        end
    end

    for (genvar b = 0; b < NUM_LINES; b++) begin : g_line
        lb_line_ram #(
            .DW (DATA_W),
            .LW (LINE_W)
        ) u_ram (
            .clk     (i_clk),
            .wr_en   (ram_we[b]),
            .wr_addr (wr_ptr),
            .wr_data (i_pixel_data),
            .rd_addr (rd_ptr),
            .taps    (taps[b])
        );
    end

    // 4:3 row mux, oldest line on top
    always_comb begin
        r1_idx = rd_idx + IDX_W'(1);
        r2_idx = rd_idx + IDX_W'(2);
        win_c  = {taps[rd_idx], taps[r1_idx], taps[r2_idx]};
    end

    // Read FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Read FSM next state: start once three lines are buffered, stop after one line
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (fill >= FILL_THR) state_nxt = RD;
            RD:   if (rd_last)          state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read FSM outputs
    always_comb begin
        rd_strobe = 1'b0;
        if (state == RD) begin
            rd_strobe = 1'b1;
        end
    end

    // Write pointer and line index
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            wr_idx <= '0;
        end else if (wr_en) begin
            if (wr_ptr == PTR_LAST) begin
                wr_ptr <= '0;
                wr_idx <= wr_idx + IDX_W'(1);
            end else begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
        end
    end

    // Read pointer and top-row line index
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr <= '0;
            rd_idx <= '0;
        end else if (rd_strobe) begin
            if (rd_last) begin
                rd_ptr <= '0;
                rd_idx <= rd_idx + IDX_W'(1);
            end else begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Fill count: pixels held but not yet swept by the read side; saturates when full
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fill <= '0;
        end else if (wr_en && !rd_strobe && !fill_full) begin
            fill <= fill + FILL_W'(1);
        end else if (rd_strobe && !wr_en) begin
            fill <= fill - FILL_W'(1);
        end
    end

    // Registered window, valid and end-of-line pulse; data holds while idle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_pixel_data       <= '0;
            o_pixel_data_valid <= 1'b0;
            o_intr             <= 1'b0;
        end else begin
            o_pixel_data_valid <= rd_strobe;
            o_intr             <= rd_strobe && rd_last;
            if (rd_strobe) begin
                o_pixel_data <= win_c;
            end
        end
    end

`ifdef LB_OVERFLOW_DET_EN
    // Sticky flag for a write refused because every line is still unread
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_overflow <= 1'b0;
        end else if (i_pixel_data_valid && fill_full && !rd_strobe) begin
            o_overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_line_buffer_window.sv
// Self-checking bench for line_buffer_window with LINE_W=8: a cycle-level
// behavioural model (pixel counts, line numbers, per-line pixel arrays) is
// compared against the DUT outputs after every clock edge, plus directed
// window constants for the documented scenarios.
module tb_line_buffer_window;

    localparam int unsigned DW = 8;
    localparam int unsigned L  = 8;
    localparam int unsigned WW = 9 * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          vin;
    logic [DW-1:0] din;
    logic [WW-1:0] dout;
    logic          vout;
    logic          intr;
`ifdef LB_OVERFLOW_DET_EN
    logic          ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Model: m_mem[line % 4][pixel] holds the most recently written pixel of that slot
    logic [DW-1:0] m_mem [4][L];
    int            m_fill;
    int            m_wr_cnt;
    int            m_rd_lines;
    int            m_pos;
    bit            m_rd;
    bit            m_valid;
    bit            m_intr;
    bit            m_ovf;
    logic [WW-1:0] m_win;

    always #5 clk = ~clk;

    line_buffer_window #(
        .DATA_W (DW),
        .LINE_W (L)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_pixel_data       (din),
        .i_pixel_data_valid (vin),
        .o_pixel_data       (dout),
        .o_pixel_data_valid (vout),
        .o_intr             (intr)
`ifdef LB_OVERFLOW_DET_EN
        ,
        .o_overflow         (ovf)
`endif
    );

    task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
            $error("check %s differs", tag);
        end
    endtask

    // Window whose top row is line number top_line, starting at column p
    function automatic logic [WW-1:0] model_window(input int top_line, input int p);
        logic [WW-1:0] w;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w = {w[WW-DW-1:0], m_mem[(top_line + r) % 4][(p + c) % L]};
            end
        end
        return w;
    endfunction

    // Drive one cycle, advance the model through the same edge, then compare
    task automatic step(input bit r, input bit v, input logic [DW-1:0] d);
        bit strobe;
        bit full;
        bit drop;
        bit wr;
        int old_fill;
        rst = r;
        vin = v;
        din = d;
        if (r) begin
            m_fill     = 0;
            m_wr_cnt   = 0;
            m_rd_lines = 0;
            m_pos      = 0;
            m_rd       = 0;
            m_valid    = 0;
            m_intr     = 0;
            m_ovf      = 0;
            m_win      = '0;
        end else begin
            strobe = m_rd;
            full   = (m_fill == 4 * L);
`ifdef LB_OVERFLOW_DET_EN
            drop   = v && full && !strobe;
            if (drop) m_ovf = 1;
`else
            drop   = 0;
`endif
            wr      = v && !drop;
            m_valid = strobe;
            m_intr  = strobe && (m_pos == L - 1);
            if (strobe) m_win = model_window(m_rd_lines, m_pos);
            if (wr) begin
                m_mem[(m_wr_cnt / L) % 4][m_wr_cnt % L] = d;
                m_wr_cnt++;
            end
            old_fill = m_fill;
            if (wr && !strobe && m_fill < 4 * L) m_fill++;
            else if (strobe && !wr)              m_fill--;
            if (!m_rd) begin
                if (old_fill >= 3 * L) m_rd = 1;
            end else if (m_pos == L - 1) begin
                m_pos = 0;
                m_rd_lines++;
                m_rd = 0;
            end else begin
                m_pos++;
            end
        end
        @(posedge clk);
        #1;
        check("valid", WW'(vout), WW'(m_valid));
        check("intr",  WW'(intr), WW'(m_intr));
        check("data",  dout, m_win);
`ifdef LB_OVERFLOW_DET_EN
        check("overflow", WW'(ovf), WW'(m_ovf));
`endif
    endtask

    initial begin
        logic [WW-1:0] w_first;
        logic [WW-1:0] w_last;
        logic [WW-1:0] w_next;
        w_first = {8'd0, 8'd1, 8'd2, 8'd8,  8'd9,  8'd10, 8'd16, 8'd17, 8'd18};
        w_last  = {8'd7, 8'd0, 8'd1, 8'd15, 8'd8,  8'd9,  8'd23, 8'd16, 8'd17};
        w_next  = {8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18, 8'd24, 8'd25, 8'd26};
        rst = 1'b1;
        vin = 1'b0;
        din = '0;

        // Reset state
        step(1, 0, 0);
        step(1, 0, 0);
        check("reset_data", dout, WW'(0));

        // Scenario 1: 23 pixels, nothing read yet
        for (int i = 0; i < 23; i++) step(0, 1, DW'(i));
        check("s1_no_valid", WW'(vout), WW'(0));

        // Scenario 2: pixel 23 triggers the first line read two edges later
        step(0, 1, DW'(23));
        step(0, 0, 0);
        check("s2_wait", WW'(vout), WW'(0));
        step(0, 0, 0);
        check("s2_first_valid", WW'(vout), WW'(1));
        check("s2_first_win", dout, w_first);
        for (int i = 0; i < 6; i++) step(0, 0, 0);
        step(0, 0, 0);
        check("s2_last_win", dout, w_last);
        check("s2_last_intr", WW'(intr), WW'(1));
        step(0, 0, 0);
        check("s2_end_valid", WW'(vout), WW'(0));
        check("s2_hold", dout, w_last);

        // Scenario 3: one more line rotates the window down by a line
        for (int i = 24; i < 32; i++) step(0, 1, DW'(i));
        step(0, 0, 0);
        step(0, 0, 0);
        check("s3_first_win", dout, w_next);
        for (int i = 0; i < 10; i++) step(0, 0, 0);

        // Scenario 4: continuous stream with writes overlapping reads
        step(1, 0, 0);
        for (int i = 0; i < 64; i++) step(0, 1, DW'(i));
        for (int i = 0; i < 40; i++) step(0, 0, 0);

        // Scenario 4b: random pixel values with random gaps
        step(1, 0, 0);
        for (int i = 0; i < 80; i++) step(0, $urandom_range(0, 3) != 0, DW'($urandom));
        for (int i = 0; i < 40; i++) step(0, 0, 0);

        // Scenario 5: reset in the middle of a line read, then restream
        step(1, 0, 0);
        for (int i = 0; i < 24; i++) step(0, 1, DW'(i));
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        step(1, 0, 0);
        check("s5_rst_valid", WW'(vout), WW'(0));
        check("s5_rst_intr",  WW'(intr), WW'(0));
        for (int i = 0; i < 24; i++) step(0, 1, DW'(i));
        step(0, 0, 0);
        check("s5_wait", WW'(vout), WW'(0));
        step(0, 0, 0);
        check("s5_first_win", dout, w_first);
        for (int i = 0; i < 10; i++) step(0, 0, 0);

`ifdef LB_OVERFLOW_DET_EN
        // Scenario 6: sustained stream until all four lines are full
        step(1, 0, 0);
        for (int i = 0; i < 130; i++) step(0, 1, DW'($urandom));
        for (int i = 0; i < 40; i++) step(0, 0, 0);
        check("s6_sticky", WW'(ovf), WW'(1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
